// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared state encoding, response codes and round-robin helper
// for the AXI-Lite arbiters.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AW   = 2'd1,
    ST_W    = 2'd2,
    ST_B    = 2'd3
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic int rr_next(input int g, input int n);
    return (g + 1 >= n) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first requester at or after
// the pointer, wrapping, as one-hot and index.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o
);

  logic found;

  // Outer loop walks offsets from the pointer so the nearest requester wins.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (!found && (j == ((int'(ptr_i) + i) % N)) && req_i[j]) begin
          found     = 1'b1;
          gnt_o[j]  = 1'b1;
          gnt_idx_o = IW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/axi_lite_write_arbiter.sv
// rtl/axi_lite_write_arbiter.sv - round-robin AW/W/B arbiter, one write in flight.
// AXI_LITE_WARB_TIMEOUT_EN adds a B-channel watchdog that answers SLVERR itself.
module axi_lite_write_arbiter
  import axi_lite_pkg::*;
#(
  parameter int NUM_MASTERS     = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int TRANS_W_STRB_W  = 4,
  parameter int TRANS_WR_RESP_W = 2,
  parameter int TRANS_PROT      = 3,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic                                  clk_i,
  input  logic                                  resetn_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]     i_s_axi_awaddr,
  input  logic [NUM_MASTERS*TRANS_PROT-1:0]     i_s_axi_awprot,
  input  logic [NUM_MASTERS-1:0]                i_s_axi_awvalid,
  output logic [NUM_MASTERS-1:0]                o_s_axi_awready,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]     i_s_axi_wdata,
  input  logic [NUM_MASTERS*TRANS_W_STRB_W-1:0] i_s_axi_wstrb,
  input  logic [NUM_MASTERS-1:0]                i_s_axi_wvalid,
  output logic [NUM_MASTERS-1:0]                o_s_axi_wready,
  output logic [NUM_MASTERS*TRANS_WR_RESP_W-1:0] o_s_axi_bresp,
  output logic [NUM_MASTERS-1:0]                o_s_axi_bvalid,
  input  logic [NUM_MASTERS-1:0]                i_s_axi_bready,
  output logic [ADDR_WIDTH-1:0]                 o_m_axi_awaddr,
  output logic [TRANS_PROT-1:0]                 o_m_axi_awprot,
  output logic                                  o_m_axi_awvalid,
  input  logic                                  i_m_axi_awready,
  output logic [DATA_WIDTH-1:0]                 o_m_axi_wdata,
  output logic [TRANS_W_STRB_W-1:0]             o_m_axi_wstrb,
  output logic                                  o_m_axi_wvalid,
  input  logic                                  i_m_axi_wready,
  input  logic [TRANS_WR_RESP_W-1:0]            i_m_axi_bresp,
  input  logic                                  i_m_axi_bvalid,
  output logic                                  o_m_axi_bready,
  output logic [$clog2(NUM_MASTERS)-1:0]        o_grant
);

  localparam int GW = $clog2(NUM_MASTERS);
  localparam int RW = TRANS_WR_RESP_W;

  state_e          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   ptr_q, ptr_d;

  logic [NUM_MASTERS-1:0] arb_gnt;
  logic [GW-1:0]          arb_idx;
  logic                   arb_any;

  logic [NUM_MASTERS-1:0]    sel_g;
  logic [ADDR_WIDTH-1:0]     awaddr_g;
  logic [TRANS_PROT-1:0]     awprot_g;
  logic                      awvalid_g;
  logic [DATA_WIDTH-1:0]     wdata_g;
  logic [TRANS_W_STRB_W-1:0] wstrb_g;
  logic                      wvalid_g;
  logic                      bready_g;
  logic [RW-1:0]             bresp_g;

  rr_arbiter #(
    .N  (NUM_MASTERS),
    .IW (GW)
  ) u_rr_arbiter (
    .req_i     (i_s_axi_awvalid),
    .ptr_i     (ptr_q),
    .gnt_o     (arb_gnt),
    .gnt_idx_o (arb_idx)
  );

  assign arb_any = |arb_gnt;
  assign o_grant = grant_q;

`ifdef AXI_LITE_WARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] to_cnt_q, to_cnt_d;
  logic          timed_out;
  assign timed_out = (to_cnt_q == CW'(TIMEOUT_CYCLES));
`endif

  // Granted master's upstream signals, selected once and shared by every state.
  always_comb begin
    sel_g     = '0;
    awaddr_g  = '0;
    awprot_g  = '0;
    awvalid_g = 1'b0;
    wdata_g   = '0;
    wstrb_g   = '0;
    wvalid_g  = 1'b0;
    bready_g  = 1'b0;
    for (int m = 0; m < NUM_MASTERS; m++) begin
      if (grant_q == GW'(m)) begin
        sel_g[m]  = 1'b1;
        awaddr_g  = i_s_axi_awaddr[m*ADDR_WIDTH +: ADDR_WIDTH];
        awprot_g  = i_s_axi_awprot[m*TRANS_PROT +: TRANS_PROT];
        awvalid_g = i_s_axi_awvalid[m];
        wdata_g   = i_s_axi_wdata[m*DATA_WIDTH +: DATA_WIDTH];
        wstrb_g   = i_s_axi_wstrb[m*TRANS_W_STRB_W +: TRANS_W_STRB_W];
        wvalid_g  = i_s_axi_wvalid[m];
        bready_g  = i_s_axi_bready[m];
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    ptr_d           = ptr_q;
    bresp_g         = RW'(RESP_OKAY);
    o_s_axi_awready = '0;
    o_s_axi_wready  = '0;
    o_s_axi_bvalid  = '0;
    o_s_axi_bresp   = '0;
    o_m_axi_awaddr  = '0;
    o_m_axi_awprot  = '0;
    o_m_axi_awvalid = 1'b0;
    o_m_axi_wdata   = '0;
    o_m_axi_wstrb   = '0;
    o_m_axi_wvalid  = 1'b0;
    o_m_axi_bready  = 1'b0;
`ifdef AXI_LITE_WARB_TIMEOUT_EN
    to_cnt_d        = to_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
`ifdef AXI_LITE_WARB_TIMEOUT_EN
        // Swallow any response that arrives after the watchdog already answered.
        o_m_axi_bready = 1'b1;
`endif
        if (arb_any) begin
          grant_d = arb_idx;
          state_d = ST_AW;
        end
      end

      ST_AW: begin
        o_m_axi_awaddr  = awaddr_g;
        o_m_axi_awprot  = awprot_g;
        o_m_axi_awvalid = awvalid_g;
        o_s_axi_awready = sel_g & {NUM_MASTERS{i_m_axi_awready}};
        if (awvalid_g && i_m_axi_awready) begin
          state_d = ST_W;
        end
      end

      ST_W: begin
        o_m_axi_wdata  = wdata_g;
        o_m_axi_wstrb  = wstrb_g;
        o_m_axi_wvalid = wvalid_g;
        o_s_axi_wready = sel_g & {NUM_MASTERS{i_m_axi_wready}};
        if (wvalid_g && i_m_axi_wready) begin
          state_d = ST_B;
`ifdef AXI_LITE_WARB_TIMEOUT_EN
          to_cnt_d = '0;
`endif
        end
      end

      ST_B: begin
`ifdef AXI_LITE_WARB_TIMEOUT_EN
        if (timed_out) begin
          bresp_g        = RW'(RESP_SLVERR);
          o_s_axi_bvalid = sel_g;
          if (bready_g) begin
            state_d = ST_IDLE;
            ptr_d   = GW'(rr_next(int'(grant_q), NUM_MASTERS));
          end
        end else begin
          bresp_g        = i_m_axi_bresp;
          o_s_axi_bvalid = sel_g & {NUM_MASTERS{i_m_axi_bvalid}};
          o_m_axi_bready = bready_g;
          if (!i_m_axi_bvalid) begin
            to_cnt_d = to_cnt_q + 1'b1;
          end else if (bready_g) begin
            state_d = ST_IDLE;
            ptr_d   = GW'(rr_next(int'(grant_q), NUM_MASTERS));
          end
        end
`else
        bresp_g        = i_m_axi_bresp;
        o_s_axi_bvalid = sel_g & {NUM_MASTERS{i_m_axi_bvalid}};
        o_m_axi_bready = bready_g;
        if (i_m_axi_bvalid && bready_g) begin
          state_d = ST_IDLE;
          ptr_d   = GW'(rr_next(int'(grant_q), NUM_MASTERS));
        end
`endif
        for (int m = 0; m < NUM_MASTERS; m++) begin
          if (sel_g[m]) begin
            o_s_axi_bresp[m*RW +: RW] = bresp_g;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      ptr_q    <= '0;
`ifdef AXI_LITE_WARB_TIMEOUT_EN
      to_cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      ptr_q    <= ptr_d;
`ifdef AXI_LITE_WARB_TIMEOUT_EN
      to_cnt_q <= to_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_axi_lite_write_arbiter.sv
// tb/tb_axi_lite_write_arbiter.sv - directed vector table plus hand-written
// back-pressure and watchdog sequences for axi_lite_write_arbiter.
module tb_axi_lite_write_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic [63:0] s_awaddr;
  logic [5:0]  s_awprot;
  logic [1:0]  s_awvalid, s_awready;
  logic [63:0] s_wdata;
  logic [7:0]  s_wstrb;
  logic [1:0]  s_wvalid, s_wready;
  logic [3:0]  s_bresp;
  logic [1:0]  s_bvalid, s_bready;
  logic [31:0] m_awaddr;
  logic [2:0]  m_awprot;
  logic        m_awvalid, m_awready;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wvalid, m_wready;
  logic [1:0]  m_bresp;
  logic        m_bvalid, m_bready;
  logic        grant;

  always #5 clk = ~clk;

  axi_lite_write_arbiter #(
    .NUM_MASTERS    (2),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk_i           (clk),
    .resetn_i        (resetn),
    .i_s_axi_awaddr  (s_awaddr),
    .i_s_axi_awprot  (s_awprot),
    .i_s_axi_awvalid (s_awvalid),
    .o_s_axi_awready (s_awready),
    .i_s_axi_wdata   (s_wdata),
    .i_s_axi_wstrb   (s_wstrb),
    .i_s_axi_wvalid  (s_wvalid),
    .o_s_axi_wready  (s_wready),
    .o_s_axi_bresp   (s_bresp),
    .o_s_axi_bvalid  (s_bvalid),
    .i_s_axi_bready  (s_bready),
    .o_m_axi_awaddr  (m_awaddr),
    .o_m_axi_awprot  (m_awprot),
    .o_m_axi_awvalid (m_awvalid),
    .i_m_axi_awready (m_awready),
    .o_m_axi_wdata   (m_wdata),
    .o_m_axi_wstrb   (m_wstrb),
    .o_m_axi_wvalid  (m_wvalid),
    .i_m_axi_wready  (m_wready),
    .i_m_axi_bresp   (m_bresp),
    .i_m_axi_bvalid  (m_bvalid),
    .o_m_axi_bready  (m_bready),
    .o_grant         (grant)
  );

`ifdef AXI_LITE_WARB_TIMEOUT_EN
  localparam logic IB = 1'b1;
`else
  localparam logic IB = 1'b0;
`endif

  typedef struct {
    logic        rst_n;
    logic [1:0]  aw;
    logic [1:0]  br;
    logic [1:0]  bresp;
    logic [84:0] exp;
    string       nm;
  } vec_t;

  vec_t        vq[$];
  logic [34:0] aw_c [2];
  logic [35:0] w_c  [2];
  logic [84:0] act;
  int          nvec = 0;
  int          nerr = 0;

  assign act = {m_awvalid, m_wvalid, m_bready, s_awready, s_wready, s_bvalid,
                s_bresp, grant, m_awprot, m_awaddr, m_wstrb, m_wdata};

  task automatic chk(input string nm, input logic [84:0] a, input logic [84:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  // st: 0 IDLE, 1 AW, 2 W, 3 B; g: granted master (and o_grant shown in IDLE).
  function automatic void add(input logic rst_n, input logic [1:0] aw, input logic [1:0] br,
                              input logic [1:0] bresp, input int st, input int g,
                              input string nm);
    vec_t v;
    logic gb;
    gb       = g[0];
    v.rst_n  = rst_n;
    v.aw     = aw;
    v.br     = br;
    v.bresp  = bresp;
    v.nm     = nm;
    v.exp    = {st == 1, st == 2,
                (st == 3) ? br[gb] : ((st == 0) ? IB : 1'b0),
                (st == 1) ? (2'b01 << g) : 2'b00,
                (st == 2) ? (2'b01 << g) : 2'b00,
                (st == 3) ? (2'b01 << g) : 2'b00,
                (st == 3) ? ({2'b00, bresp} << (2 * g)) : 4'b0000,
                gb,
                (st == 1) ? aw_c[gb] : 35'd0,
                (st == 2) ? w_c[gb] : 36'd0};
    vq.push_back(v);
  endfunction

  initial begin
    int  prev;
    int  g;
    logic seen;

    aw_c[0] = {3'd0, 32'h0000_1000};
    aw_c[1] = {3'd1, 32'h0000_3000};
    w_c[0]  = {4'hF, 32'hDEAD_BEEF};
    w_c[1]  = {4'h3, 32'h1234_5678};
    s_awaddr  = {aw_c[1][31:0], aw_c[0][31:0]};
    s_awprot  = {aw_c[1][34:32], aw_c[0][34:32]};
    s_wdata   = {w_c[1][31:0], w_c[0][31:0]};
    s_wstrb   = {w_c[1][35:32], w_c[0][35:32]};
    resetn    = 1'b0;
    s_awvalid = '0;
    s_wvalid  = '0;
    s_bready  = '0;
    m_awready = 1'b0;
    m_wready  = 1'b0;
    m_bvalid  = 1'b0;
    m_bresp   = 2'b00;

    add(1'b0, 2'b00, 2'b00, 2'b00, 0, 0, "reset");
    add(1'b1, 2'b01, 2'b11, 2'b00, 0, 0, "m0_idle");
    add(1'b1, 2'b01, 2'b11, 2'b00, 1, 0, "m0_aw");
    add(1'b1, 2'b01, 2'b11, 2'b00, 2, 0, "m0_w");
    add(1'b1, 2'b00, 2'b11, 2'b00, 3, 0, "m0_b");
    add(1'b1, 2'b00, 2'b11, 2'b00, 0, 0, "m0_done");
    add(1'b0, 2'b11, 2'b11, 2'b00, 0, 0, "reset2");
    prev = 0;
    for (int k = 0; k < 6; k++) begin
      g = k % 2;
      add(1'b1, 2'b11, 2'b11, 2'b00, 0, prev, $sformatf("rr%0d_idle", k));
      add(1'b1, 2'b11, 2'b11, 2'b00, 1, g, $sformatf("rr%0d_aw", k));
      add(1'b1, 2'b11, 2'b11, 2'b00, 2, g, $sformatf("rr%0d_w", k));
      add(1'b1, 2'b11, 2'b11, (k == 1) ? 2'b10 : 2'b00, 3, g, $sformatf("rr%0d_b", k));
      prev = g;
    end
    add(1'b1, 2'b10, 2'b11, 2'b00, 0, 1, "m1_idle");
    add(1'b1, 2'b10, 2'b11, 2'b00, 1, 1, "m1_aw");
    add(1'b1, 2'b10, 2'b11, 2'b00, 2, 1, "m1_w");
    add(1'b0, 2'b10, 2'b11, 2'b00, 0, 0, "m1_rst_in_w");
    add(1'b1, 2'b10, 2'b11, 2'b00, 0, 0, "m1_idle2");
    add(1'b1, 2'b10, 2'b11, 2'b00, 1, 1, "m1_aw2");
    add(1'b1, 2'b10, 2'b11, 2'b00, 2, 1, "m1_w2");
    add(1'b1, 2'b00, 2'b11, 2'b00, 3, 1, "m1_b2");
    add(1'b1, 2'b00, 2'b11, 2'b00, 0, 1, "m1_done");

    repeat (2) @(posedge clk);
    #2;
    m_awready = 1'b1;
    m_wready  = 1'b1;
    m_bvalid  = 1'b1;
    foreach (vq[i]) begin
      resetn    = vq[i].rst_n;
      s_awvalid = vq[i].aw;
      s_wvalid  = vq[i].aw;
      s_bready  = vq[i].br;
      m_bresp   = vq[i].bresp;
      #1;
      chk(vq[i].nm, act, vq[i].exp);
      @(posedge clk);
      #2;
    end

    // Downstream stalls AW: hold the address, never leak W early, and let master1 wait.
    s_awvalid = 2'b11;
    s_wvalid  = 2'b11;
    s_bready  = 2'b11;
    m_awready = 1'b0;
    m_bresp   = 2'b00;
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      #1;
      if (m_awvalid) seen = 1'b1;
      else begin
        @(posedge clk);
        #2;
      end
    end
    chk("stall_aw_seen", 85'(seen), 85'(1'b1));
    chk("stall_aw_grant", 85'({grant, m_awaddr}), 85'({1'b0, 32'h0000_1000}));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #3;
      chk($sformatf("stall_aw_hold%0d", i), 85'({m_awvalid, s_awready, m_wvalid, s_wready}),
          85'(6'b100000));
    end
    m_awready = 1'b1;
    @(posedge clk);
    #3;
    chk("stall_w", 85'({m_wvalid, s_wready, m_wdata}), 85'({3'b101, 32'hDEAD_BEEF}));
    @(posedge clk);
    #3;
    chk("stall_b", 85'({s_bvalid, m_bready}), 85'(3'b011));
    s_awvalid = 2'b10;
    s_wvalid  = 2'b10;
    @(posedge clk);
    #3;
    chk("stall_idle", 85'({m_awvalid, s_awready, s_bvalid}), 85'(5'b00000));
    @(posedge clk);
    #3;
    chk("waiter_aw", 85'({grant, m_awvalid, m_awaddr}), 85'({2'b11, 32'h0000_3000}));
    s_awvalid = 2'b00;
    repeat (3) @(posedge clk);
    #2;
    s_wvalid = 2'b00;

`ifdef AXI_LITE_WARB_TIMEOUT_EN
    resetn = 1'b0;
    @(posedge clk);
    #2;
    resetn    = 1'b1;
    s_awvalid = 2'b01;
    s_wvalid  = 2'b01;
    s_bready  = 2'b01;
    m_awready = 1'b1;
    m_wready  = 1'b1;
    m_bvalid  = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    s_awvalid = 2'b00;
    s_wvalid  = 2'b00;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("to_wait%0d", k), 85'(s_bvalid), 85'(2'b00));
      @(posedge clk);
      #2;
    end
    #1;
    chk("to_slverr", 85'({s_bvalid, s_bresp}), 85'({2'b01, 4'b0010}));
    @(posedge clk);
    #2;
    m_bvalid = 1'b1;
    #1;
    chk("to_absorb", 85'({m_bready, s_bvalid}), 85'(3'b100));
    @(posedge clk);
    #2;
    m_bvalid = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
